// File: rtl/hazard_pkg.sv
// Shared definitions for the IF/ID hazard controller: opcodes, field slices, FSM states.
package hazard_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam int OP_HI = 31;
    localparam int OP_LO = 26;
    localparam int RS_HI = 25;
    localparam int RS_LO = 21;
    localparam int RT_HI = 20;
    localparam int RT_LO = 16;

    typedef enum logic {RUN, STALL} state_t;

    // Only these opcodes read rt as a source; for I-type ALU ops rt is a destination.
    function automatic logic uses_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/hazard_cmp.sv
// Load-use compare: does the instruction in IF/ID source the register a load in EX writes?
module hazard_cmp
    import hazard_pkg::*;
(
    input  logic [5:0] op,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic       ex_memread,
    input  logic [4:0] ex_rd,
    output logic       hazard
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit = (ex_rd == rs);
    assign rt_hit = uses_rt(op) && (ex_rd == rt);
    // $zero is never really written, so a load targeting it cannot create a dependency.
    assign hazard = ex_memread && (ex_rd != 5'd0) && (rs_hit || rt_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// IF/ID hold/flush control with load-use stall FSM.
// Define HAZARD_PERF_EN to add saturating stall/flush event counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int LU_STALL_CYC = 1,
    parameter int CNT_W        = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [31:0]      inst_i,
    input  logic             ex_memread_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             branch_taken_i,
    output logic             HD_o,
    output logic             flush_o,
    output logic             pc_write_o,
    output logic             bubble_o
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
`endif
);

    localparam int CW = $clog2(LU_STALL_CYC + 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          hazard;
    logic          stall_now;
    logic          unused_imm;

    assign unused_imm = ^inst_i[15:0];

    hazard_cmp u_cmp (
        .op         (inst_i[OP_HI:OP_LO]),
        .rs         (inst_i[RS_HI:RS_LO]),
        .rt         (inst_i[RT_HI:RT_LO]),
        .ex_memread (ex_memread_i),
        .ex_rd      (ex_rd_i),
        .hazard     (hazard)
    );

    // The first stall cycle is spent in RUN, so STALL only covers the remaining LU_STALL_CYC-1.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (hazard && (LU_STALL_CYC > 1)) begin
                        state <= STALL;
                        cnt   <= CW'(LU_STALL_CYC - 1);
                    end
                end
                STALL: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1))
                        state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

    // Outputs are combinational and gated by reset so an abort takes effect the same cycle.
    assign stall_now  = rst_i && ((state == STALL) || hazard);
    assign HD_o       = stall_now;
    assign bubble_o   = stall_now;
    assign pc_write_o = !stall_now;
    assign flush_o    = rst_i && !stall_now && branch_taken_i;

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (HD_o && (stall_cnt_o != '1))
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            if (flush_o && (flush_cnt_o != '1))
                flush_cnt_o <= flush_cnt_o + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one instance with LU_STALL_CYC=1, one with 3, shared stimulus.
module tb_hazard_ctrl;

    localparam int CNT_W = 32;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] inst_i;
    logic        ex_memread_i;
    logic [4:0]  ex_rd_i;
    logic        branch_taken_i;

    logic hd1, fl1, pc1, bb1;
    logic hd3, fl3, pc3, bb3;
`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] sc1, fc1, sc3, fc3;
`endif

    int vecs = 0;
    int errs = 0;

    always #5 clk_i = ~clk_i;

    hazard_ctrl #(.LU_STALL_CYC(1), .CNT_W(CNT_W)) u_dut1 (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .inst_i         (inst_i),
        .ex_memread_i   (ex_memread_i),
        .ex_rd_i        (ex_rd_i),
        .branch_taken_i (branch_taken_i),
        .HD_o           (hd1),
        .flush_o        (fl1),
        .pc_write_o     (pc1),
        .bubble_o       (bb1)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cnt_o    (sc1),
        .flush_cnt_o    (fc1)
`endif
    );

    hazard_ctrl #(.LU_STALL_CYC(3), .CNT_W(CNT_W)) u_dut3 (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .inst_i         (inst_i),
        .ex_memread_i   (ex_memread_i),
        .ex_rd_i        (ex_rd_i),
        .branch_taken_i (branch_taken_i),
        .HD_o           (hd3),
        .flush_o        (fl3),
        .pc_write_o     (pc3),
        .bubble_o       (bb3)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cnt_o    (sc3),
        .flush_cnt_o    (fc3)
`endif
    );

    // Output vectors packed as {HD, flush, pc_write, bubble}.
    localparam logic [3:0] O_RUN   = 4'b0010;
    localparam logic [3:0] O_STALL = 4'b1001;
    localparam logic [3:0] O_FLUSH = 4'b0110;

    wire [3:0] o1 = {hd1, fl1, pc1, bb1};
    wire [3:0] o3 = {hd3, fl3, pc3, bb3};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] inst, input logic mr, input logic [4:0] rd, input logic br);
        inst_i         = inst;
        ex_memread_i   = mr;
        ex_rd_i        = rd;
        branch_taken_i = br;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i = 1'b0;
        drive(32'h00441820, 1'b1, 5'd2, 1'b0);
        #2;
        chk("reset_d1", 32'(o1), 32'(O_RUN));
        chk("reset_d3", 32'(o3), 32'(O_RUN));
`ifdef HAZARD_PERF_EN
        chk("reset_sc3", sc3, 0);
        chk("reset_fc3", fc3, 0);
`endif

        tick(); rst_i = 1'b1; drive(32'h0, 1'b0, 5'd0, 1'b0); #2;
        chk("idle_d1", 32'(o1), 32'(O_RUN));
        chk("idle_d3", 32'(o3), 32'(O_RUN));

        // load-use on rs, add $3,$2,$4
        tick(); drive(32'h00441820, 1'b1, 5'd2, 1'b0); #2;
        chk("lu_rs_c1_d1", 32'(o1), 32'(O_STALL));
        chk("lu_rs_c1_d3", 32'(o3), 32'(O_STALL));
        tick(); drive(32'h0, 1'b0, 5'd0, 1'b0); #2;
        chk("lu_rs_c2_d1", 32'(o1), 32'(O_RUN));
        chk("lu_rs_c2_d3", 32'(o3), 32'(O_STALL));
`ifdef HAZARD_PERF_EN
        chk("lu_rs_sc1", sc1, 1);
        chk("lu_rs_sc3", sc3, 1);
`endif
        tick(); #2;
        chk("lu_rs_c3_d3", 32'(o3), 32'(O_STALL));
        tick(); #2;
        chk("lu_rs_c4_d3", 32'(o3), 32'(O_RUN));
`ifdef HAZARD_PERF_EN
        chk("lu_rs_sc3_end", sc3, 3);
`endif

        // load-use on rt via sw $2,0($5); inputs held through the stall
        tick(); drive(32'hACA20000, 1'b1, 5'd2, 1'b0); #2;
        chk("sw_c1_d3", 32'(o3), 32'(O_STALL));
        tick(); #2;
        chk("sw_c2_d3", 32'(o3), 32'(O_STALL));
        tick(); #2;
        chk("sw_c3_d3", 32'(o3), 32'(O_STALL));
        tick(); drive(32'h0, 1'b0, 5'd0, 1'b0); #2;
        chk("sw_c4_d3", 32'(o3), 32'(O_RUN));

        // rt of R-type (add $3,$4,$2) and of beq $4,$2
        tick(); drive(32'h00821820, 1'b1, 5'd2, 1'b0); #2;
        chk("rtype_rt_d1", 32'(o1), 32'(O_STALL));
        tick(); drive(32'h0, 1'b0, 5'd0, 1'b0);
        tick(); tick(); #2;
        chk("rtype_rt_end_d3", 32'(o3), 32'(O_RUN));
        tick(); drive(32'h10820003, 1'b1, 5'd2, 1'b0); #2;
        chk("beq_rt_d1", 32'(o1), 32'(O_STALL));
        tick(); drive(32'h0, 1'b0, 5'd0, 1'b0);
        tick(); tick(); #2;
        chk("beq_rt_end_d3", 32'(o3), 32'(O_RUN));

        // no false stalls
        tick(); drive(32'h20220005, 1'b1, 5'd2, 1'b0); #2;
        chk("addi_rt_d1", 32'(o1), 32'(O_RUN));
        chk("addi_rt_d3", 32'(o3), 32'(O_RUN));
        drive(32'h00441820, 1'b0, 5'd2, 1'b0); #1;
        chk("no_memread", 32'(o1), 32'(O_RUN));
        drive(32'h00001820, 1'b1, 5'd0, 1'b0); #1;
        chk("zero_reg", 32'(o1), 32'(O_RUN));
        drive(32'h00000000, 1'b1, 5'd0, 1'b0); #1;
        chk("nop", 32'(o3), 32'(O_RUN));

        // taken branch
        tick(); drive(32'h10430003, 1'b0, 5'd0, 1'b1); #2;
        chk("br_d1", 32'(o1), 32'(O_FLUSH));
        chk("br_d3", 32'(o3), 32'(O_FLUSH));
`ifdef HAZARD_PERF_EN
        chk("br_fc1_before", fc1, 0);
`endif
        tick(); drive(32'h0, 1'b0, 5'd0, 1'b0); #2;
        chk("br_after_d1", 32'(o1), 32'(O_RUN));
`ifdef HAZARD_PERF_EN
        chk("br_fc1_after", fc1, 1);
`endif

        // load-use and taken branch together: stall wins, flush follows
        tick(); drive(32'h00441820, 1'b1, 5'd2, 1'b1); #2;
        chk("both_c1_d1", 32'(o1), 32'(O_STALL));
        chk("both_c1_d3", 32'(o3), 32'(O_STALL));
        tick(); drive(32'h10430003, 1'b0, 5'd0, 1'b1); #2;
        chk("both_c2_d1", 32'(o1), 32'(O_FLUSH));
        chk("both_c2_d3", 32'(o3), 32'(O_STALL));
        tick(); #2;
        chk("both_c3_d3", 32'(o3), 32'(O_STALL));
        tick(); #2;
        chk("both_c4_d3", 32'(o3), 32'(O_FLUSH));
        tick(); drive(32'h0, 1'b0, 5'd0, 1'b0);

        // reset during stall cycle 2
        tick(); drive(32'h00441820, 1'b1, 5'd2, 1'b0); #2;
        chk("rst_c1_d3", 32'(o3), 32'(O_STALL));
        tick(); drive(32'h0, 1'b0, 5'd0, 1'b0); #2;
        chk("rst_c2_d3", 32'(o3), 32'(O_STALL));
        rst_i = 1'b0; #1;
        chk("rst_abort_d3", 32'(o3), 32'(O_RUN));
`ifdef HAZARD_PERF_EN
        chk("rst_sc3", sc3, 0);
        chk("rst_fc3", fc3, 0);
`endif
        tick(); rst_i = 1'b1; #2;
        chk("rst_release_d3", 32'(o3), 32'(O_RUN));
        tick(); #2;
        chk("rst_run_d3", 32'(o3), 32'(O_RUN));
`ifdef HAZARD_PERF_EN
        chk("rst_sc3_after", sc3, 0);
        chk("rst_fc1_after", fc1, 0);
`endif

        // a fresh stall after reset still lasts exactly three cycles
        tick(); drive(32'h00441820, 1'b1, 5'd2, 1'b0); #2;
        chk("re_c1_d3", 32'(o3), 32'(O_STALL));
        tick(); drive(32'h0, 1'b0, 5'd0, 1'b0); #2;
        chk("re_c2_d3", 32'(o3), 32'(O_STALL));
        tick(); #2;
        chk("re_c3_d3", 32'(o3), 32'(O_STALL));
        tick(); #2;
        chk("re_c4_d3", 32'(o3), 32'(O_RUN));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Control source for the IF/ID pipeline register's HD_i (hold) and flush_i (zero) inputs.
- Watches the instruction currently held in IF/ID against a load in EX; stalls on load-use for a configurable number of cycles; flushes on taken branch.
- Also drives PC write-enable and the ID/EX bubble select.
- Sequential: a small FSM plus a stall down-counter, and optional saturating event counters.

Parameters:
- LU_STALL_CYC, 1, load-use stall length in cycles (>=1); >1 models slow data memory.
- CNT_W, 32, width of the optional event counters.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- inst_i  input  32  instruction currently in IF/ID (IF/ID inst_o).
- ex_memread_i  input  1  instruction in EX is a load.
- ex_rd_i  input  5  destination register of the EX instruction.
- branch_taken_i  input  1  branch in ID resolved taken this cycle.
- HD_o  output  1  hold IF/ID (to IF/ID HD_i).
- flush_o  output  1  zero IF/ID (to IF/ID flush_i).
- pc_write_o  output  1  PC update enable.
- bubble_o  output  1  force ID/EX control fields to zero.
- stall_cnt_o  output  CNT_W  stall-cycle count (HAZARD_PERF_EN only).
- flush_cnt_o  output  CNT_W  flush count (HAZARD_PERF_EN only).

Behaviour:
- Decode: rs=inst_i[25:21], rt=inst_i[20:16], op=inst_i[31:26].
- uses_rt=1 for op 6'b000000 (R-type), 6'b000100 (beq) and 6'b101011 (sw); uses_rt=0 otherwise.
- hazard = ex_memread_i & (ex_rd_i!=0) & (ex_rd_i==rs | (uses_rt & ex_rd_i==rt)).
- FSM states: RUN, STALL. Counter cnt has width $clog2(LU_STALL_CYC+1).
- RUN:
  - hazard=1: HD_o=1, pc_write_o=0, bubble_o=1 in the same cycle (combinational). If LU_STALL_CYC>1, load cnt=LU_STALL_CYC-1 and go to STALL; else stay in RUN.
  - hazard=0 and branch_taken_i=1: flush_o=1 and pc_write_o=1 for one cycle; stay in RUN.
  - Otherwise: pc_write_o=1; all other outputs 0.
- STALL:
  - HD_o=1, pc_write_o=0, bubble_o=1 regardless of inputs.
  - cnt decrements each cycle; at cnt==1, next state is RUN.
  - branch_taken_i is ignored. The branch is re-evaluated once the stall ends, because its operand may be the load result.
- Priority: hazard/stall beats flush. HD_o and flush_o are never both 1.
- Stall timing: total stall is exactly LU_STALL_CYC consecutive cycles per hazard.
- Post-flush nop: IF/ID holds the nop 0x00000000 after a flush. Its rs=rt=0, so it never causes a stall.
- Reset: while rst_i=0, state=RUN and cnt=0.
  - Outputs forced: HD_o=0, flush_o=0, bubble_o=0, pc_write_o=1.
  - A reset mid-STALL aborts the stall immediately.
- Latency: all outputs are combinational from state and inputs (0-cycle). Only state and cnt are registered.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined:
  - stall_cnt_o increments on every cycle with HD_o=1.
  - flush_cnt_o increments on every cycle with flush_o=1.
  - Both saturate at all-ones, clear to 0 on reset, and are registered, so each is visible the cycle after its event.
- Undefined: both ports and their counters are absent; all other behaviour is identical.

Decomposition:
- Shared package hazard_pkg: opcode constants OP_RTYPE=6'b000000, OP_BEQ=6'b000100, OP_SW=6'b101011; state typedef {RUN, STALL}; field-slice constants for rs and rt.
- One natural sub-module, hazard_cmp: the combinational rs/rt compare producing hazard. It can be reused later for a forwarding unit.
- FSM and counters stay in hazard_ctrl.

Test Plan:
- Load-use on rs: inst_i=0x00441820 (add $3,$2,$4), ex_memread_i=1, ex_rd_i=2, LU_STALL_CYC=1 -> HD_o=1, pc_write_o=0, bubble_o=1 for exactly one cycle, then normal.
- Load-use on rt via sw, LU_STALL_CYC=3: inst_i=0xACA20000 (sw $2,0($5)), ex_rd_i=2 -> HD_o=1 for 3 consecutive cycles; FSM is in STALL for cycles 2-3.
- No false stalls:
  - addi: inst_i=0x20220005 (addi $2,$1,5), ex_rd_i=2 -> no stall, because rt is not a source for addi.
  - $zero: ex_rd_i=0 with inst_i rs=0 -> no stall.
- Taken branch: branch_taken_i=1, hazard=0 -> flush_o=1, HD_o=0, pc_write_o=1 for one cycle. With HAZARD_PERF_EN, flush_cnt_o goes 0->1 the next cycle.
- Simultaneous load-use and taken branch -> HD_o=1, flush_o=0. After the stall, with branch_taken_i still 1 -> flush_o=1.
- Reset mid-stall, LU_STALL_CYC=3: drop rst_i in stall cycle 2 -> immediately HD_o=0, pc_write_o=1. After release, state is RUN and counters read 0.
